// File: rtl/lcd_bus_sequencer_pkg.sv
// Shared types, default 50 MHz timing and command helpers for the HD44780 bus sequencer.
package lcd_pkg;

    // Bus phases of one write transaction.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_E_HIGH    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_EXEC_WAIT = 3'd4
    } lcd_state_e;

    // Default phase lengths in clk cycles at 50 MHz.
    localparam int DEF_SETUP_CYC  = 2;      // >= 40 ns address setup
    localparam int DEF_E_HIGH_CYC = 12;     // >= 230 ns enable pulse
    localparam int DEF_HOLD_CYC   = 1;      // address/data hold after E falls
    localparam int DEF_EXEC_CYC   = 2000;   // 40 us normal execution time
    localparam int DEF_CLEAR_CYC  = 80000;  // 1.6 ms for clear / return home

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear Display and Return Home (0x02/0x03, bit 0 is don't-care) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == 7'b0000001));
    endfunction

    // Largest of the phase lengths; sizes the shared phase counter.
    function automatic int max_cyc(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter shared by every bus phase; stops at zero instead of wrapping.
module lcd_cycle_timer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Sole owner of the HD44780 bus: arbitrates two byte-write requesters (0 has fixed
// priority) and sequences setup, E pulse, hold and controller execution wait.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int E_HIGH_CYC = DEF_E_HIGH_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int EXEC_CYC   = DEF_EXEC_CYC,
    parameter int CLEAR_CYC  = DEF_CLEAR_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       grant
);

    localparam int MAX_CYC = max_cyc(SETUP_CYC, E_HIGH_CYC, HOLD_CYC, EXEC_CYC, CLEAR_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);

    lcd_state_e       state_q;
    logic             lcd_rs_q;
    logic [7:0]       lcd_data_q;
    logic             lcd_e_q;
    logic             busy_q;
    logic             grant_q;

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;
    logic             accept0;
    logic             accept1;

    // Ready is withheld while reset is asserted so no handshake completes then.
    assign req0_ready = (state_q == ST_IDLE) && !reset;
    assign req1_ready = (state_q == ST_IDLE) && !reset && !req0_valid;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    lcd_cycle_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_i    (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Counter reload at every phase boundary, choosing the next phase length.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept0 || accept1) begin
                    timer_load = 1'b1;
                    timer_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = E_LD;
                end
            end
            ST_E_HIGH: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = is_long_cmd(lcd_rs_q, lcd_data_q) ? CLEAR_LD : EXEC_LD;
                end
            end
            default: begin
            end
        endcase
    end

    // Phase sequencer with registered bus outputs; rs/data only change on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            lcd_e_q    <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept0) begin
                        lcd_rs_q   <= req0_rs;
                        lcd_data_q <= req0_data;
                        grant_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end else if (accept1) begin
                        lcd_rs_q   <= req1_rs;
                        lcd_data_q <= req1_data;
                        grant_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_zero) begin
                        lcd_e_q <= 1'b1;
                        state_q <= ST_E_HIGH;
                    end
                end
                ST_E_HIGH: begin
                    if (timer_zero) begin
                        lcd_e_q <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
                        state_q <= ST_EXEC_WAIT;
                    end
                end
                ST_EXEC_WAIT: begin
                    if (timer_zero) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    lcd_e_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = lcd_e_q;
    assign lcd_data = lcd_data_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer: single/long/arbitrated writes, mid-pulse reset, streaming.
module tb_lcd_bus_sequencer;

    localparam int SETUP  = 2;
    localparam int EHIGH  = 12;
    localparam int HOLD   = 1;
    localparam int EXEC   = 2000;
    localparam int CLEAR  = 5000;   // shortened long wait keeps the run small

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       lcd_rs, lcd_rw, lcd_e, busy, grant;
    logic [7:0] lcd_data;

    int checks = 0;
    int failures = 0;
    int pulse_total = 0;

    always #5 clk = ~clk;

    lcd_bus_sequencer #(
        .SETUP_CYC  (SETUP),
        .E_HIGH_CYC (EHIGH),
        .HOLD_CYC   (HOLD),
        .EXEC_CYC   (EXEC),
        .CLEAR_CYC  (CLEAR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data),
        .busy       (busy),
        .grant      (grant)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one write from the current sample point and follow it until IDLE returns.
    task automatic run_txn(input int port, input logic rs, input logic [7:0] data,
                           input int wait_cyc);
        int total, e_cnt, e_first, e_last, stab_err, rw_err, idle_k, rises;
        logic e_prev;
        total = SETUP + EHIGH + HOLD + wait_cyc;
        if (port == 0) begin
            req0_valid = 1'b1; req0_rs = rs; req0_data = data;
            check_eq("ready0_pre", req0_ready, 1);
        end else begin
            req1_valid = 1'b1; req1_rs = rs; req1_data = data;
            check_eq("ready1_pre", req1_ready, 1);
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        check_eq("grant", grant, port);
        check_eq("data_latch", lcd_data, data);
        check_eq("rs_latch", lcd_rs, rs);
        check_eq("busy_start", busy, 1);
        e_cnt = 0; e_first = -1; e_last = -1; stab_err = 0; rw_err = 0;
        idle_k = -1; rises = 0; e_prev = 1'b0;
        for (int k = 0; k <= total + 8 && idle_k < 0; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (lcd_e) begin
                e_cnt++;
                if (e_first < 0) e_first = k;
                e_last = k;
            end
            if (lcd_e && !e_prev) rises++;
            e_prev = lcd_e;
            if ((lcd_e || (e_last >= 0 && k == e_last + 1)) &&
                (lcd_data !== data || lcd_rs !== rs)) stab_err++;
            if (lcd_rw !== 1'b0) rw_err++;
            if (!busy) idle_k = k;
        end
        check_eq("e_first", e_first, SETUP);
        check_eq("e_width", e_cnt, EHIGH);
        check_eq("e_pulses", rises, 1);
        check_eq("bus_stable", stab_err, 0);
        check_eq("rw_low", rw_err, 0);
        check_eq("idle_at", idle_k, total);
        check_eq("ready0_post", req0_ready, 1);
        pulse_total += rises;
        $display("txn port=%0d rs=%0d data=%02h idle_after=%0d", port, rs, data, idle_k);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_e", lcd_e, 0);
        check_eq("rst_rs", lcd_rs, 0);
        check_eq("rst_rw", lcd_rw, 0);
        check_eq("rst_data", lcd_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_ready0", req0_ready, 1);
        check_eq("rst_ready1", req1_ready, 1);

        // Normal data write, then long-wait commands.
        run_txn(1, 1'b1, 8'h41, EXEC);
        run_txn(0, 1'b0, 8'h01, CLEAR);
        run_txn(0, 1'b0, 8'h03, CLEAR);

        // Arbitration: both valid, requester 0 first, requester 1 at next IDLE.
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h42;
        req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 8'h38;
        #1;
        check_eq("arb_ready1_blocked", req1_ready, 0);
        run_txn(0, 1'b0, 8'h38, EXEC);
        run_txn(1, 1'b1, 8'h42, EXEC);

        // Reset while E is high.
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_e_high", lcd_e, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_e", lcd_e, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_data", lcd_data, 0);
        check_eq("mid_rst_rs", lcd_rs, 0);
        check_eq("mid_rst_grant", grant, 0);
        check_eq("mid_rst_ready", req0_ready, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_ready", req0_ready, 1);
        run_txn(0, 1'b1, 8'h33, EXEC);

        // Stream 20 data bytes on requester 1.
        pulse_total = 0;
        for (int i = 0; i < 20; i++) begin
            run_txn(1, 1'b1, 8'h60 + 8'(i), EXEC);
        end
        check_eq("stream_pulses", pulse_total, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
Owns the HD44780 bus of the 4x20 character LCD and is the only block that drives lcd_rs/lcd_rw/lcd_e/lcd_data.
- Accepts byte-write requests from two requesters through valid/ready handshakes:
  - port 0: LCD_Initilizer;
  - port 1: LCD_Driver refresh engine.
- Arbitrates between them with fixed priority and generates bus timing for each write: address setup, E pulse width, hold, then the controller's execution wait.
- Replaces the combinational initilizer_done mux and the per-requester E timing in the LCD top level.

Parameters:
SETUP_CYC, 2, clk cycles RS/DATA stable before E rises (>=40 ns at 50 MHz); legal range >=1
E_HIGH_CYC, 12, clk cycles E held high (>=230 ns); legal range >=1
HOLD_CYC, 1, clk cycles RS/DATA held after E falls; legal range >=1
EXEC_CYC, 2000, clk cycles busy wait after a normal command or data write (40 us)
CLEAR_CYC, 80000, clk cycles busy wait after Clear Display / Return Home (1.6 ms)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 (initializer) has a write pending
req0_rs  in  1  requester 0 register select (0 = command, 1 = data)
req0_data  in  8  requester 0 byte
req0_ready  out  1  requester 0 write accepted this cycle when valid && ready
req1_valid  in  1  requester 1 (driver) has a write pending
req1_rs  in  1  requester 1 register select
req1_data  in  8  requester 1 byte
req1_ready  out  1  requester 1 accept strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; constant 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_data  out  8  LCD data byte
busy  out  1  high in every state except IDLE
grant  out  1  requester index of the transaction in flight or last accepted

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state IDLE; lcd_rs, lcd_rw, lcd_e, lcd_data, busy, grant, and the cycle counter all 0.
- States: IDLE -> SETUP -> E_HIGH -> HOLD -> EXEC_WAIT -> IDLE.
- Ready logic, combinational:
  - req0_ready = (state == IDLE);
  - req1_ready = (state == IDLE) && !req0_valid.
- Accept: on a clk edge in IDLE with reqN_valid && reqN_ready:
  - latch rs/data into lcd_rs/lcd_data;
  - set grant = N;
  - load the counter with SETUP_CYC-1;
  - go to SETUP.
- Arbitration: if both requesters are valid in IDLE, requester 0 wins. Requester 1 waits; there is no starvation guard, because requester 0 goes quiet after initialization.
- SETUP: lcd_e = 0. When the counter reaches 0, load E_HIGH_CYC-1 and go to E_HIGH.
- E_HIGH: lcd_e = 1 for exactly E_HIGH_CYC cycles. lcd_e is registered, so its first high cycle is SETUP_CYC cycles after the accept edge.
- HOLD: lcd_e = 0 for HOLD_CYC cycles, then load the wait count and go to EXEC_WAIT.
- Wait count selection:
  - CLEAR_CYC-1 when latched rs == 0 and (data == 8'h01 or data[7:1] == 7'b0000001);
  - EXEC_CYC-1 otherwise.
- EXEC_WAIT: when the counter reaches 0, go to IDLE.
- Held bus values: lcd_rs and lcd_data keep the latched values from the accept edge until the next accept. They never change while lcd_e is high or during HOLD.
- Transaction length: accept edge to next possible accept = SETUP_CYC + E_HIGH_CYC + HOLD_CYC + wait + 1 cycles. The +1 is the IDLE cycle in which ready is sampled.
- Requests that arrive while busy are not accepted; ready stays low. A valid that drops before acceptance is simply ignored; there is no error.
- Reset mid-transaction: on the next edge all outputs go to their reset values, lcd_e is forced low, the latched byte is discarded, and no ready is issued in that cycle.
- Counter width: $clog2(max(all *_CYC)) bits, unsigned down-count. A counter at 0 never wraps to all-ones.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - default timing constants at 50 MHz;
  - command codes CMD_CLEAR = 8'h01 and CMD_HOME = 8'h02;
  - a function is_long_cmd(rs, data) implementing the wait count selection rule.
- Sub-module lcd_cycle_timer: a loadable down-counter with load, load_val, and a zero flag. It is used once for all phase timing.

Test Plan:
- Reset, then idle for 10 cycles -> all outputs 0, req0_ready = req1_ready = 1.
- req1 sends rs=1, data=8'h41 at edge T -> lcd_data = 41 and lcd_rs = 1 from T+1; lcd_e high on exactly cycles T+2..T+13; busy falls and ready returns at T+2016.
- req0 sends rs=0, data=8'h01 -> lcd_e pulse as above; no accept possible until 80016 cycles after the accept edge; the variant data=8'h03 gives the same long wait.
- Both requesters valid in IDLE (req0 = 8'h38 command, req1 = 8'h42 data) -> req0 accepted first with grant = 0; req1 accepted at the next IDLE with grant = 1, and lcd_data shows 8'h38 and then 8'h42 in order.
- Assert reset while lcd_e is high (cycle T+5) -> lcd_e = 0 and state IDLE at the next edge; a new request is accepted normally afterwards.
- Stream 20 back-to-back data bytes on req1 -> exactly 20 E pulses, each at least 12 cycles wide; lcd_data is stable throughout every pulse and its hold cycle; lcd_rw stays 0 throughout.
